// File: rtl/present_pkg.sv
// PRESENT-80 constants, FSM encoding and key-schedule / permutation helpers
// shared by the decryption core.
package present_pkg;

  localparam int NUM_ROUNDS = 31;

  // Entry n sits in nibble n (index 0 is the least significant nibble).
  localparam logic [15:0][3:0] SBOX     = 64'h21748FE3DA09B65C;
  localparam logic [15:0][3:0] INV_SBOX = 64'hA970364BD21C8FE5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    KEY_EXP = 2'd1,
    DECRYPT = 2'd2,
    OUT     = 2'd3
  } fsm_t;

  function automatic logic [79:0] key_update_fwd(input logic [79:0] key, input logic [4:0] rc);
    logic [79:0] k;
    k = {key[18:0], key[79:19]};
    k[79:76] = SBOX[k[79:76]];
    k[19:15] = k[19:15] ^ rc;
    return k;
  endfunction

  // Undoes key_update_fwd step by step in reverse order.
  function automatic logic [79:0] key_update_inv(input logic [79:0] key, input logic [4:0] rc);
    logic [79:0] k;
    k = key;
    k[19:15] = k[19:15] ^ rc;
    k[79:76] = INV_SBOX[k[79:76]];
    return {k[60:0], k[79:61]};
  endfunction

  // Forward pLayer moves bit i to (16*i) mod 63, so bit i is fetched back from there.
  function automatic logic [63:0] inv_perm(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 63; i++) begin
      y[i] = x[(i * 16) % 63];
    end
    y[63] = x[63];
    return y;
  endfunction

endpackage

// File: rtl/inv_sub_per.sv
// Combinational inverse round datapath: inverse bit permutation, then
// sixteen parallel inverse S-boxes.
module inv_sub_per
  import present_pkg::*;
(
  input  logic [63:0] din,
  output logic [63:0] dout
);

  logic [63:0] perm;

  always_comb begin
    perm = inv_perm(din);
    dout = '0;
    for (int i = 0; i < 16; i++) begin
      dout[4*i +: 4] = INV_SBOX[perm[4*i +: 4]];
    end
  end

endmodule

// File: rtl/present_decryptor_top.sv
// Iterative PRESENT-80 decryptor: caches K32 after a 31-cycle key expansion,
// then undoes one round per cycle; key, ciphertext and plaintext use valid/ready.
module present_decryptor_top
  import present_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [79:0] key_i,
  input  logic        key_valid_i,
  output logic        key_ready_o,
  input  logic [63:0] data_i,
  input  logic        data_valid_i,
  output logic        data_ready_o,
  output logic [63:0] data_o,
  output logic        data_valid_o,
  input  logic        data_ready_i
);

  localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS);

  fsm_t        fsm;
  logic [63:0] state;
  logic [79:0] wkey;
  logic [79:0] k32;
  logic [4:0]  round;
  logic        key_ok;

  logic [63:0] t;
  logic [63:0] inv_out;

  assign t = state ^ wkey[79:16];

  inv_sub_per u_inv_sub_per (
    .din  (t),
    .dout (inv_out)
  );

  // A key offered together with data wins, so data is refused in that cycle.
  assign key_ready_o  = (fsm == IDLE);
  assign data_ready_o = (fsm == IDLE) && key_ok && !key_valid_i;
  assign data_valid_o = (fsm == OUT);
  assign data_o       = (fsm == OUT) ? t : 64'd0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fsm    <= IDLE;
      state  <= '0;
      wkey   <= '0;
      k32    <= '0;
      round  <= '0;
      key_ok <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (key_valid_i) begin
            wkey   <= key_i;
            round  <= 5'd1;
            key_ok <= 1'b0;
            fsm    <= KEY_EXP;
          end else if (data_valid_i && key_ok) begin
            state <= data_i;
            wkey  <= k32;
            round <= LAST_ROUND;
            fsm   <= DECRYPT;
          end
        end
        KEY_EXP: begin
          wkey <= key_update_fwd(wkey, round);
          if (round == LAST_ROUND) begin
            k32    <= key_update_fwd(wkey, round);
            key_ok <= 1'b1;
            fsm    <= IDLE;
          end else begin
            round <= round + 5'd1;
          end
        end
        DECRYPT: begin
          state <= inv_out;
          wkey  <= key_update_inv(wkey, round);
          // Final whitening with K1 happens combinationally on the output.
          if (round == 5'd1) begin
            fsm <= OUT;
          end else begin
            round <= round - 5'd1;
          end
        end
        OUT: begin
          if (data_ready_i) begin
            fsm <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_present_decryptor_top.sv
// Directed bench for present_decryptor_top using published PRESENT-80 vectors.
module tb_present_decryptor_top;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [79:0] key_i;
  logic        key_valid_i;
  logic        key_ready_o;
  logic [63:0] data_i;
  logic        data_valid_i;
  logic        data_ready_o;
  logic [63:0] data_o;
  logic        data_valid_o;
  logic        data_ready_i;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk_i = ~clk_i;

  present_decryptor_top dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .key_i        (key_i),
    .key_valid_i  (key_valid_i),
    .key_ready_o  (key_ready_o),
    .data_i       (data_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .data_ready_i (data_ready_i)
  );

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Counts cycles from the key-accept edge until data_ready_o rises.
  task automatic load_key(input string tag, input logic [79:0] k);
    int n;
    key_i       = k;
    key_valid_i = 1'b1;
    #1;
    chk({tag, "_key_ready"}, 80'(key_ready_o), 80'd1);
    @(posedge clk_i);
    #1;
    key_valid_i = 1'b0;
    n = 0;
    @(negedge clk_i);
    while (!data_ready_o && n < 100) begin
      n++;
      @(negedge clk_i);
    end
    chk({tag, "_key_latency"}, 80'(n), 80'd31);
  endtask

  task automatic decrypt(input string tag, input logic [63:0] ct, input logic [63:0] pt, input int hold);
    int n;
    data_i       = ct;
    data_valid_i = 1'b1;
    #1;
    chk({tag, "_data_ready"}, 80'(data_ready_o), 80'd1);
    @(posedge clk_i);
    #1;
    data_valid_i = 1'b0;
    n = 0;
    @(negedge clk_i);
    while (!data_valid_o && n < 100) begin
      n++;
      @(negedge clk_i);
    end
    chk({tag, "_latency"}, 80'(n), 80'd31);
    chk({tag, "_plaintext"}, 80'(data_o), 80'(pt));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_i);
      chk({tag, "_hold_data"}, 80'(data_o), 80'(pt));
      chk({tag, "_hold_valid"}, 80'(data_valid_o), 80'd1);
      chk({tag, "_hold_rdy"}, {78'd0, key_ready_o, data_ready_o}, 80'd0);
    end
    data_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    data_ready_i = 1'b0;
    chk({tag, "_valid_drop"}, 80'(data_valid_o), 80'd0);
    chk({tag, "_back_idle"}, 80'(key_ready_o), 80'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni       = 1'b0;
    key_i        = '0;
    key_valid_i  = 1'b0;
    data_i       = '0;
    data_valid_i = 1'b0;
    data_ready_i = 1'b0;
    #12;
    chk("rst_key_ready", 80'(key_ready_o), 80'd1);
    chk("rst_data_ready", 80'(data_ready_o), 80'd0);
    chk("rst_data_valid", 80'(data_valid_o), 80'd0);
    chk("rst_data_o", 80'(data_o), 80'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Ciphertext before any key must never be taken.
    data_i       = 64'h5579C1387B228445;
    data_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("nokey_data_ready", 80'(data_ready_o), 80'd0);
      chk("nokey_data_valid", 80'(data_valid_o), 80'd0);
    end
    data_valid_i = 1'b0;

    load_key("k0", 80'd0);
    decrypt("k0_ct0", 64'h5579C1387B228445, 64'h0000000000000000, 0);

    load_key("kf", {80{1'b1}});
    decrypt("kf_ct0", 64'hE72C46C0F5945049, 64'h0000000000000000, 0);
    decrypt("kf_ctf", 64'h3333DCD3213210D2, 64'hFFFFFFFFFFFFFFFF, 0);

    // Key and data together: only the key is accepted.
    key_i        = 80'd0;
    key_valid_i  = 1'b1;
    data_i       = 64'h0123456789ABCDEF;
    data_valid_i = 1'b1;
    #1;
    chk("both_data_ready", 80'(data_ready_o), 80'd0);
    chk("both_key_ready", 80'(key_ready_o), 80'd1);
    @(posedge clk_i);
    #1;
    key_valid_i  = 1'b0;
    data_valid_i = 1'b0;
    begin
      int n;
      n = 0;
      @(negedge clk_i);
      while (!data_ready_o && n < 100) begin
        chk("both_no_output", 80'(data_valid_o), 80'd0);
        n++;
        @(negedge clk_i);
      end
      chk("both_key_latency", 80'(n), 80'd31);
    end
    decrypt("k0_ctf_hold", 64'hA112FFC72F68417B, 64'hFFFFFFFFFFFFFFFF, 10);

    // Reset in the middle of a decryption.
    data_i       = 64'h5579C1387B228445;
    data_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    data_valid_i = 1'b0;
    repeat (16) @(posedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("midrst_data_valid", 80'(data_valid_o), 80'd0);
    chk("midrst_key_ready", 80'(key_ready_o), 80'd1);
    chk("midrst_data_ready", 80'(data_ready_o), 80'd0);
    @(negedge clk_i);
    rst_ni       = 1'b1;
    data_valid_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("postrst_data_ready", 80'(data_ready_o), 80'd0);
      chk("postrst_data_valid", 80'(data_valid_o), 80'd0);
    end
    data_valid_i = 1'b0;
    load_key("reload", 80'd0);
    decrypt("reload_ct0", 64'h5579C1387B228445, 64'h0000000000000000, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
